// File: rtl/mmcm_reset_sequencer_if.sv
// Control/status bundle between the MMCM reset sequencer and its surroundings.
// The slave side is the sequencer; the master side drives lock/restart and observes status.
interface mmcm_reset_sequencer_if #(
  parameter int RC_W = 2
);
  logic            locked_in;
  logic            restart;
  logic            mmcm_rst;
  logic            sys_rst;
  logic            ready;
  logic            fault;
  logic [RC_W-1:0] retry_count;
  logic [2:0]      state_dbg;

  modport master (
    output locked_in, restart,
    input  mmcm_rst, sys_rst, ready, fault, retry_count, state_dbg
  );

  modport slave (
    input  locked_in, restart,
    output mmcm_rst, sys_rst, ready, fault, retry_count, state_dbg
  );
endinterface

// File: rtl/mmcm_reset_sequencer.sv
// Pulses the MMCM reset, waits for lock with timeout and retries, holds downstream
// logic in reset until lock has settled, and re-sequences when lock is lost.
module mmcm_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 32,
  parameter int LOCK_TIMEOUT_CYCLES = 30000,
  parameter int SETTLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int TIMER_W             = 16
) (
  input logic                   clk,
  input logic                   rst,
  mmcm_reset_sequencer_if.slave bus
);
  localparam int RC_W = $clog2(MAX_RETRIES + 1);
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [RC_W-1:0]    RC_MAX      = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [TIMER_W-1:0] r_timer;
  logic [RC_W-1:0]    r_retry;
  logic [RC_W-1:0]    w_next_retry;
  logic               r_sync0;
  logic               r_sync1;
  logic               w_lock_s;
  logic               w_fail;
  logic               w_timer_clr;
  logic               w_mmcm_rst;
  logic               w_sys_rst;
  logic               w_ready;
  logic               w_fault;

  // LOCKED comes from the MMCM clock domain, so it is resynchronised here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= bus.locked_in;
      r_sync1 <= r_sync0;
    end
  end

  assign w_lock_s = r_sync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ASSERT_RST;
      r_timer <= {TIMER_W{1'b0}};
      r_retry <= {RC_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_retry <= w_next_retry;
      if (w_timer_clr) begin
        r_timer <= {TIMER_W{1'b0}};
      end else begin
        r_timer <= r_timer + TIMER_W'(1);
      end
    end
  end

  // Lock loss in SETTLE outranks a same-cycle settle expiry: lock must hold throughout
  always_comb begin
    w_next_state = r_state;
    w_next_retry = r_retry;
    w_fail       = 1'b0;
    w_timer_clr  = 1'b0;
    if (bus.restart) begin
      w_next_state = ST_ASSERT_RST;
      w_next_retry = {RC_W{1'b0}};
    end else begin
      case (r_state)
        ST_ASSERT_RST: begin
          if (r_timer == RST_LAST) begin
            w_next_state = ST_WAIT_LOCK;
          end else begin
            w_next_state = ST_ASSERT_RST;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next_state = ST_SETTLE;
          end else if (r_timer == LOCK_LAST) begin
            w_fail = 1'b1;
          end else begin
            w_next_state = ST_WAIT_LOCK;
          end
        end
        ST_SETTLE: begin
          if (!w_lock_s) begin
            w_fail = 1'b1;
          end else if (r_timer == SETTLE_LAST) begin
            w_next_state = ST_RUN;
            w_next_retry = {RC_W{1'b0}};
          end else begin
            w_next_state = ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_next_state = ST_ASSERT_RST;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_FAULT: w_next_state = ST_FAULT;
        default:  w_next_state = ST_ASSERT_RST;
      endcase
      if (w_fail) begin
        if (r_retry == RC_MAX) begin
          w_next_state = ST_FAULT;
        end else begin
          w_next_state = ST_ASSERT_RST;
          w_next_retry = r_retry + RC_W'(1);
        end
      end else begin
        w_next_retry = w_next_retry;
      end
    end
    w_timer_clr = bus.restart || (w_next_state != r_state);
  end

  always_comb begin
    w_mmcm_rst = 1'b1;
    w_sys_rst  = 1'b1;
    w_ready    = 1'b0;
    w_fault    = 1'b0;
    case (r_state)
      ST_ASSERT_RST: w_mmcm_rst = 1'b1;
      ST_WAIT_LOCK:  w_mmcm_rst = 1'b0;
      ST_SETTLE:     w_mmcm_rst = 1'b0;
      ST_RUN: begin
        w_mmcm_rst = 1'b0;
        w_sys_rst  = 1'b0;
        w_ready    = 1'b1;
      end
      ST_FAULT:      w_fault = 1'b1;
      default:       w_mmcm_rst = 1'b1;
    endcase
  end

  assign bus.mmcm_rst    = w_mmcm_rst;
  assign bus.sys_rst     = w_sys_rst;
  assign bus.ready       = w_ready;
  assign bus.fault       = w_fault;
  assign bus.retry_count = r_retry;
  assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Directed bench for mmcm_reset_sequencer with short timing parameters
// (pulse 4, lock timeout 20, settle 8, two retries).
module tb_mmcm_reset_sequencer;
  localparam int RC_W = 2;
  localparam logic [2:0] S_ASSERT = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic watch_ready = 1'b0;
  logic ready_seen = 1'b0;

  mmcm_reset_sequencer_if #(.RC_W(RC_W)) bus ();

  mmcm_reset_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .SETTLE_CYCLES      (8),
    .MAX_RETRIES        (2),
    .TIMER_W            (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch_ready && bus.ready === 1'b1) ready_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges while mmcm_rst stays at lvl (capped so a stuck DUT cannot hang the run)
  task automatic count_while(input logic lvl, output int n);
    n = 0;
    while (bus.mmcm_rst === lvl && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    int n;
    n = 0;
    while (bus.state_dbg !== s && n < budget) begin
      tick();
      n++;
    end
    ok = (bus.state_dbg === s);
  endtask

  // {mmcm_rst, sys_rst, ready, fault, retry_count, state_dbg}
  function automatic logic [8:0] outs();
    return {bus.mmcm_rst, bus.sys_rst, bus.ready, bus.fault, bus.retry_count, bus.state_dbg};
  endfunction

  task automatic test_reset;
    logic [8:0] obs;
    rst = 1'b1;
    bus.locked_in = 1'b0;
    bus.restart = 1'b0;
    #3;
    obs = outs();
    vectors++;
    if (obs !== 9'b1_1_0_0_00_000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 9'b1_1_0_0_00_000);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_clean_start;
    int n;
    logic [8:0] obs;
    count_while(1'b1, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL clean_pulse_len: got %0d expected %0d", n, 4);
    end
    repeat (9) tick();
    bus.locked_in = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.state_dbg !== S_WAIT) begin
      miscompares++;
      $display("FAIL clean_still_wait: got %0d expected %0d", bus.state_dbg, S_WAIT);
    end
    tick();
    vectors++;
    if (bus.state_dbg !== S_SETTLE) begin
      miscompares++;
      $display("FAIL clean_settle_entry: got %0d expected %0d", bus.state_dbg, S_SETTLE);
    end
    repeat (7) tick();
    vectors++;
    if ({bus.sys_rst, bus.ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL clean_not_yet_ready: got %b expected %b", {bus.sys_rst, bus.ready}, 2'b10);
    end
    tick();
    obs = outs();
    vectors++;
    if (obs !== 9'b0_0_1_0_00_011) begin
      miscompares++;
      $display("FAIL clean_run: got %b expected %b", obs, 9'b0_0_1_0_00_011);
    end
  endtask

  task automatic test_never_locks;
    int n;
    bit bad;
    logic [8:0] obs;
    bus.locked_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 3; a++) begin
      vectors++;
      if ({bus.retry_count, bus.state_dbg} !== {a[1:0], S_ASSERT}) begin
        miscompares++;
        $display("FAIL nolock_attempt_start: got %b expected %b", {bus.retry_count, bus.state_dbg}, {a[1:0], S_ASSERT});
      end
      count_while(1'b1, n);
      vectors++;
      if (n !== 4) begin
        miscompares++;
        $display("FAIL nolock_pulse_len: got %0d expected %0d", n, 4);
      end
      count_while(1'b0, n);
      vectors++;
      if (n !== 20) begin
        miscompares++;
        $display("FAIL nolock_window_len: got %0d expected %0d", n, 20);
      end
    end
    obs = outs();
    vectors++;
    if (obs !== 9'b1_1_0_1_10_100) begin
      miscompares++;
      $display("FAIL nolock_fault: got %b expected %b", obs, 9'b1_1_0_1_10_100);
    end
    bad = 1'b0;
    repeat (100) begin
      tick();
      if (bus.fault !== 1'b1 || bus.mmcm_rst !== 1'b1 || bus.state_dbg !== S_FAULT) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_hold: got %b expected %b", bad, 1'b0);
    end
  endtask

  task automatic test_restart;
    int n;
    logic [8:0] obs;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    obs = outs();
    vectors++;
    if (obs !== 9'b1_1_0_0_00_000) begin
      miscompares++;
      $display("FAIL restart_from_fault: got %b expected %b", obs, 9'b1_1_0_0_00_000);
    end
    tick();
    tick();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    count_while(1'b1, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL restart_in_pulse_len: got %0d expected %0d", n, 4);
    end
    count_while(1'b0, n);
    count_while(1'b1, n);
    repeat (19) tick();
    vectors++;
    if ({bus.retry_count, bus.state_dbg} !== {2'd1, S_WAIT}) begin
      miscompares++;
      $display("FAIL restart_pre_timeout: got %b expected %b", {bus.retry_count, bus.state_dbg}, {2'd1, S_WAIT});
    end
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    vectors++;
    if ({bus.retry_count, bus.state_dbg} !== {2'd0, S_ASSERT}) begin
      miscompares++;
      $display("FAIL restart_vs_timeout: got %b expected %b", {bus.retry_count, bus.state_dbg}, {2'd0, S_ASSERT});
    end
    count_while(1'b1, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL restart_pulse_len: got %0d expected %0d", n, 4);
    end
  endtask

  task automatic test_settle_glitch;
    int n;
    bit ok;
    bus.locked_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_seen = 1'b0;
    watch_ready = 1'b1;
    count_while(1'b1, n);
    bus.locked_in = 1'b1;
    wait_state(S_SETTLE, 10, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_reach_settle: got %b expected %b", ok, 1'b1);
    end
    repeat (3) tick();
    bus.locked_in = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.state_dbg !== S_SETTLE) begin
      miscompares++;
      $display("FAIL glitch_still_settle: got %0d expected %0d", bus.state_dbg, S_SETTLE);
    end
    tick();
    bus.locked_in = 1'b1;
    vectors++;
    if ({bus.retry_count, bus.state_dbg} !== {2'd1, S_ASSERT}) begin
      miscompares++;
      $display("FAIL glitch_fail: got %b expected %b", {bus.retry_count, bus.state_dbg}, {2'd1, S_ASSERT});
    end
    count_while(1'b1, n);
    watch_ready = 1'b0;
    vectors++;
    if (ready_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_ready_pulse: got %b expected %b", ready_seen, 1'b0);
    end
    wait_state(S_RUN, 40, ok);
    vectors++;
    if ({ok, bus.ready, bus.retry_count} !== 4'b1_1_00) begin
      miscompares++;
      $display("FAIL glitch_relock_run: got %b expected %b", {ok, bus.ready, bus.retry_count}, 4'b1_1_00);
    end
  endtask

  task automatic test_run_loss;
    int n;
    bit ok;
    logic [8:0] obs;
    bus.locked_in = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.ready, bus.sys_rst} !== 2'b10) begin
      miscompares++;
      $display("FAIL loss_ready_held: got %b expected %b", {bus.ready, bus.sys_rst}, 2'b10);
    end
    tick();
    obs = outs();
    vectors++;
    if (obs !== 9'b1_1_0_0_00_000) begin
      miscompares++;
      $display("FAIL loss_resequence: got %b expected %b", obs, 9'b1_1_0_0_00_000);
    end
    count_while(1'b1, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL loss_pulse_len: got %0d expected %0d", n, 4);
    end
    bus.locked_in = 1'b1;
    wait_state(S_RUN, 40, ok);
    vectors++;
    if ({ok, bus.retry_count} !== 3'b1_00) begin
      miscompares++;
      $display("FAIL loss_relock_run: got %b expected %b", {ok, bus.retry_count}, 3'b1_00);
    end
  endtask

  task automatic test_async_reset;
    int n;
    bit ok;
    logic [8:0] obs;
    #2 rst = 1'b1;
    #1 obs = outs();
    vectors++;
    if (obs !== 9'b1_1_0_0_00_000) begin
      miscompares++;
      $display("FAIL async_rst_in_run: got %b expected %b", obs, 9'b1_1_0_0_00_000);
    end
    #1 rst = 1'b0;
    count_while(1'b1, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL async_run_pulse_len: got %0d expected %0d", n, 4);
    end
    wait_state(S_SETTLE, 20, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reach_settle: got %b expected %b", ok, 1'b1);
    end
    tick();
    tick();
    #2 rst = 1'b1;
    #1 obs = outs();
    vectors++;
    if (obs !== 9'b1_1_0_0_00_000) begin
      miscompares++;
      $display("FAIL async_rst_in_settle: got %b expected %b", obs, 9'b1_1_0_0_00_000);
    end
    #1 rst = 1'b0;
    count_while(1'b1, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL async_settle_pulse_len: got %0d expected %0d", n, 4);
    end
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_never_locks();
    test_restart();
    test_settle_glitch();
    test_run_loss();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mmcm_reset_sequencer.md
Name: mmcm_reset_sequencer

Overview:
Controls start-up and recovery of the board MMCM that derives clk_10mhz from the 300 MHz differential oscillator. It pulses the MMCM reset, waits for lock with a timeout, and holds downstream logic (LED counter and IO logic) in reset until lock has been stable. It then monitors lock and re-sequences on loss. It runs on the free-running oscillator clock (post-IBUFDS), never on the MMCM output.

Parameters:
RST_PULSE_CYCLES, 32, cycles mmcm_rst is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 30000, cycles allowed in WAIT_LOCK before an attempt fails (100 us at 300 MHz)
SETTLE_CYCLES, 1024, cycles lock must stay continuously high before release
MAX_RETRIES, 3, failed attempts tolerated after the first before FAULT
TIMER_W, 16, timer width; must hold max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, SETTLE_CYCLES)-1

Ports:
clk  in  1  oscillator clock (osc_300 after IBUFDS)
rst  in  1  asynchronous, active-high reset
locked_in  in  1  MMCM LOCKED, asynchronous to clk
restart  in  1  synchronous single-cycle request to re-run the sequence
mmcm_rst  out  1  to MMCM RST, active high
sys_rst  out  1  downstream reset, active high
ready  out  1  MMCM locked and settled
fault  out  1  retries exhausted
retry_count  out  RC_W  failed attempts in the current sequence; RC_W = $clog2(MAX_RETRIES+1)
state_dbg  out  3  encoded FSM state: 0 ASSERT_RST, 1 WAIT_LOCK, 2 SETTLE, 3 RUN, 4 FAULT

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high. While rst is high: state = ASSERT_RST, timer = 0, sync flops = 0, retry_count = 0, mmcm_rst = 1, sys_rst = 1, ready = 0, fault = 0. These values take effect immediately, with no clock edge.
- locked_in passes through a 2-flop synchronizer to give lock_s. Latency is 2 edges.
- Moore outputs are decoded from the state register and change on the same edge as the state:
  - ASSERT_RST: mmcm_rst=1, sys_rst=1, ready=0, fault=0
  - WAIT_LOCK: mmcm_rst=0, sys_rst=1, ready=0, fault=0
  - SETTLE: mmcm_rst=0, sys_rst=1, ready=0, fault=0
  - RUN: mmcm_rst=0, sys_rst=0, ready=1, fault=0
  - FAULT: mmcm_rst=1, sys_rst=1, ready=0, fault=1
- Timer clears on every state change and increments otherwise. "Expiry of N" means timer == N-1.
- ASSERT_RST: on expiry of RST_PULSE_CYCLES, go to WAIT_LOCK. mmcm_rst is high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - lock_s = 1: go to SETTLE. Lock wins over a same-cycle timeout.
  - Expiry of LOCK_TIMEOUT_CYCLES without lock: this is a failure.
- SETTLE:
  - lock_s = 0: this is a failure.
  - Expiry of SETTLE_CYCLES: go to RUN and clear retry_count.
- Failure: if retry_count == MAX_RETRIES, go to FAULT with retry_count unchanged. Otherwise increment retry_count and go to ASSERT_RST.
- RUN: lock_s = 0 goes to ASSERT_RST. This is not counted as a failure; retry_count stays 0. ready falls on the 2nd edge after locked_in is first sampled low.
- FAULT: stays in FAULT until restart or rst.
- restart has top priority in every state. Next state is ASSERT_RST, retry_count = 0, timer = 0. restart while already in ASSERT_RST restarts the pulse count.
- retry_count never exceeds MAX_RETRIES. There is no wrap.
- Unreachable state encodings go to ASSERT_RST.

Test Plan:
Test parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, SETTLE_CYCLES=8, MAX_RETRIES=2.
1. Clean start: release rst; lock model raises locked_in 10 cycles after mmcm_rst falls -> mmcm_rst high exactly 4 cycles; state goes to SETTLE on the 2nd edge after locked_in is sampled high; ready=1 and sys_rst=0 on the 10th edge; retry_count=0.
2. Never locks: locked_in tied 0 -> three 4-cycle mmcm_rst pulses separated by 20-cycle WAIT_LOCK windows; retry_count 0->1->2; then FAULT with fault=1 and mmcm_rst=1 held for at least 100 further cycles.
3. Settle glitch: lock achieved, then locked_in low for 3 cycles at SETTLE timer=5 -> return to ASSERT_RST with retry_count=1; ready never pulses; a clean second lock reaches RUN with retry_count=0.
4. Loss in RUN: drop locked_in -> ready=0 and sys_rst=1 on the 2nd edge, mmcm_rst pulses 4 cycles, retry_count stays 0, RUN is reached again after re-lock.
5. restart: assert in FAULT -> ASSERT_RST next edge, fault=0, retry_count=0. Assert on the same cycle as a WAIT_LOCK timeout at retry_count=1 -> ASSERT_RST with retry_count=0, not 2.
6. Async reset mid-operation: assert rst between edges in RUN and in SETTLE -> all outputs reach reset values before the next edge; after release the sequence restarts from a full 4-cycle mmcm_rst pulse.
